// File: rtl/fft_pkg.sv
// Shared FFT helpers: default frame geometry and the bit-reversal
// function, used by the reorder buffer and the shuffle-index generator.
package fft_pkg;

    // log2 of the frame length and the sample width used when a client
    // does not override them.
    localparam int N_DEFAULT = 3;
    localparam int W_DEFAULT = 16;

    // Mirror the low n bits of k (bit i moves to bit n-1-i). Bits above
    // n-1 of the result are zero; callers truncate to their index width.
    function automatic logic [31:0] rev_bits(input logic [31:0] k, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < n; i++) begin
            r = {r[30:0], k[i]};
        end
        return r;
    endfunction

endpackage : fft_pkg

// File: rtl/reorder_bank_ram.sv
// One bank of the ping-pong reorder storage: 2^N x W, one synchronous
// write port and one asynchronous read port.
module reorder_bank_ram #(
    parameter int N = 3,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         we,
    input  logic [N-1:0] waddr,
    input  logic [W-1:0] wdata,
    input  logic [N-1:0] raddr,
    output logic [W-1:0] rdata
);

    logic [W-1:0] mem [2**N];

    // Capture the incoming sample at its bit-reversed address.
    // NOTE: storage is deliberately left out of reset; the full flags in
    // the parent decide whether its contents mean anything.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : reorder_bank_ram

// File: rtl/bitrev_reorder_buf.sv
// Bit-reversed to natural-order frame reorder buffer. Input frames are
// written scattered (address = rev(k)) into one bank while the other bank
// is read out linearly, so a full bank always holds a natural-order frame.
module bitrev_reorder_buf
    import fft_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [N-1:0] out_idx,
    output logic         out_last
);

    localparam logic [N-1:0] CNT_MAX = '1;

    logic [N-1:0] wr_cnt;
    logic [N-1:0] rd_cnt;
    logic         wr_bank;
    logic         rd_bank;
    logic [1:0]   full;
    logic [1:0]   full_nxt;

    logic         in_fire;
    logic         out_fire;
    logic         wr_wrap;
    logic         rd_wrap;
    logic [N-1:0] wr_addr;
    logic [W-1:0] rd_data [2];

    // Handshakes depend only on registered state, so there is no
    // combinational path from in_valid/out_ready to the ready/valid outputs.
    assign in_ready  = ~full[wr_bank];
    assign out_valid = full[rd_bank];
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign wr_wrap   = (wr_cnt == CNT_MAX);
    assign rd_wrap   = (rd_cnt == CNT_MAX);
    assign wr_addr   = N'(rev_bits(32'(wr_cnt), N));

    // Both banks share address/data; only the write enable is steered.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        reorder_bank_ram #(
            .N (N),
            .W (W)
        ) u_ram (
            .clk   (clk),
            .we    (in_fire && (wr_bank == 1'(b))),
            .waddr (wr_addr),
            .wdata (in_data),
            .raddr (rd_cnt),
            .rdata (rd_data[b])
        );
    end

    assign out_data = rd_data[rd_bank];
    assign out_idx  = rd_cnt;
    assign out_last = out_valid & rd_wrap;

    // Next full flags: a fill and a drain on the same edge always target
    // different banks (the fill needs an empty bank, the drain a full one),
    // so both updates are applied independently.
    // NOTE: every comb output gets a default first so no latch is inferred.
    always_comb begin
        full_nxt = full;
        if (in_fire && wr_wrap) begin
            full_nxt[wr_bank] = 1'b1;
        end
        if (out_fire && rd_wrap) begin
            full_nxt[rd_bank] = 1'b0;
        end
    end

    // Full-flag register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= '0;
        end else begin
            full <= full_nxt;
        end
    end

    // Write side: count accepted samples and flip banks after the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
        end else if (in_fire) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_wrap) begin
                wr_bank <= ~wr_bank;
            end
        end
    end

    // Read side: step through the full bank and flip banks after the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt  <= '0;
            rd_bank <= 1'b0;
        end else if (out_fire) begin
            rd_cnt <= rd_cnt + 1'b1;
            if (rd_wrap) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

endmodule : bitrev_reorder_buf

// File: tb/tb_bitrev_reorder_buf.sv
// Self-checking bench for bitrev_reorder_buf (N=3, W=16): a table-driven
// single frame, hand-built corner sequences and a randomized run, all
// compared against a frame-queue reference model.
module tb_bitrev_reorder_buf;

    localparam int N  = 3;
    localparam int W  = 16;
    localparam int FL = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [N-1:0] out_idx;
    logic         out_last;

    bitrev_reorder_buf #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: samples of the frame being collected, and the
    // natural-order samples of completed frames still waiting to go out.
    logic [W-1:0] part [$];
    logic [W-1:0] exp_q [$];

    // Per-sequence statistics, measured on the DUT outputs.
    int n_in_acc;
    int n_out_acc;
    int n_ir_low;
    int n_ov_low;

    typedef struct {
        logic [W-1:0] din;
        logic [W-1:0] dout;
        logic [N-1:0] idx;
        logic         last;
    } vec_t;

    vec_t vec [FL];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int brev(input int k);
        int r;
        r = 0;
        for (int i = 0; i < N; i++) begin
            r = r * 2 + (k >> i) % 2;
        end
        return r;
    endfunction

    task automatic clear_stats();
        n_in_acc  = 0;
        n_out_acc = 0;
        n_ir_low  = 0;
        n_ov_low  = 0;
    endtask

    // One clock cycle: called at posedge+1, drives inputs, checks outputs
    // against the model, then advances the model across the edge.
    task automatic step(input logic iv, input logic [W-1:0] d, input logic ordy);
        int  pend;
        int  idx;
        bit  m_ir;
        bit  m_ov;
        bit  in_fire;
        bit  out_fire;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        pend = (exp_q.size() + FL - 1) / FL;
        m_ir = (pend < 2);
        m_ov = (pend >= 1);
        check("in_ready", in_ready, m_ir);
        check("out_valid", out_valid, m_ov);
        if (m_ov) begin
            idx = (FL - exp_q.size() % FL) % FL;
            check("out_data", out_data, exp_q[0]);
            check("out_idx", out_idx, idx);
            check("out_last", out_last, idx == FL - 1);
        end
        if (!in_ready) n_ir_low++;
        if (!out_valid) n_ov_low++;
        in_fire  = iv && m_ir;
        out_fire = ordy && m_ov;
        @(posedge clk);
        #1;
        if (out_fire) begin
            void'(exp_q.pop_front());
            n_out_acc++;
        end
        if (in_fire) begin
            n_in_acc++;
            part.push_back(d);
            if (part.size() == FL) begin
                for (int j = 0; j < FL; j++) begin
                    exp_q.push_back(part[brev(j)]);
                end
                part.delete();
            end
        end
    endtask

    // Complete any partial frame with filler, then empty the buffer.
    task automatic flush();
        for (int i = 0; i < 2 * FL && part.size() != 0; i++) begin
            step(1'b1, W'($urandom), 1'b1);
        end
        for (int i = 0; i < 3 * FL; i++) begin
            step(1'b0, '0, 1'b1);
        end
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        for (int i = 0; i < FL; i++) begin
            vec[i].din  = W'(i);
            vec[i].idx  = N'(i);
            vec[i].last = (i == FL - 1);
        end
        vec[0].dout = 16'd0; vec[1].dout = 16'd4; vec[2].dout = 16'd2; vec[3].dout = 16'd6;
        vec[4].dout = 16'd1; vec[5].dout = 16'd5; vec[6].dout = 16'd3; vec[7].dout = 16'd7;

        // Outputs while held in reset.
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_last", out_last, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single frame from the table: reorder, index, last and latency.
        clear_stats();
        for (int i = 0; i < FL; i++) begin
            check("tbl_no_early_valid", out_valid, 0);
            step(1'b1, vec[i].din, 1'b1);
        end
        for (int i = 0; i < FL; i++) begin
            check("tbl_out_valid", out_valid, 1);
            check("tbl_out_data", out_data, vec[i].dout);
            check("tbl_out_idx", out_idx, vec[i].idx);
            check("tbl_out_last", out_last, vec[i].last);
            step(1'b0, '0, 1'b1);
        end
        check("tbl_drained", out_valid, 0);

        // Four back-to-back frames: no input bubbles, no output gaps.
        clear_stats();
        for (int i = 0; i < 4 * FL; i++) begin
            step(1'b1, W'(16'h1000 + i), 1'b1);
            if (i == FL - 1) n_ov_low = 0;
        end
        for (int i = 0; i < FL; i++) begin
            step(1'b0, '0, 1'b1);
        end
        check("b2b_in_ready_low_cycles", n_ir_low, 0);
        check("b2b_out_gap_cycles", n_ov_low, 0);
        check("b2b_outputs", n_out_acc, 4 * FL);

        // Backpressure: 20 samples offered with out_ready low.
        clear_stats();
        for (int i = 0; i < 24; i++) begin
            step(1'b1, W'(16'h2000 + n_in_acc), 1'b0);
        end
        check("bp_accepted", n_in_acc, 2 * FL);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        for (int i = 0; i < 20 && n_in_acc < 20; i++) begin
            step(1'b1, W'(16'h2000 + n_in_acc), 1'b1);
            if (i == 0) check("bp_held_at_drain_start", n_in_acc, 2 * FL);
        end
        check("bp_all_accepted", n_in_acc, 20);
        flush();

        // out_ready toggling every cycle: outputs must hold across stalls.
        clear_stats();
        for (int i = 0; i < FL; i++) begin
            step(1'b1, vec[i].din, 1'b0);
        end
        for (int i = 0; i < 2 * FL; i++) begin
            step(1'b0, '0, logic'(i % 2));
        end
        check("tog_outputs", n_out_acc, FL);
        check("tog_drained", out_valid, 0);

        // Fill of frame 2 and drain of frame 1 on the same edge.
        clear_stats();
        for (int i = 0; i < FL; i++) begin
            step(1'b1, W'(16'h3000 + i), 1'b0);
        end
        for (int i = 0; i < FL; i++) begin
            step(1'b1, W'(16'h3100 + i), 1'b1);
        end
        check("align_out_valid", out_valid, 1);
        check("align_in_ready", in_ready, 1);
        check("align_out_idx", out_idx, 0);
        check("align_out_data", out_data, 16'h3100);
        n_ov_low = 0;
        for (int i = 0; i < FL; i++) begin
            step(1'b0, '0, 1'b1);
        end
        check("align_no_gap", n_ov_low, 0);
        check("align_outputs", n_out_acc, 2 * FL);

        // Reset in the middle of a frame.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, W'(16'h4000 + i), 1'b1);
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_idx", out_idx, 0);
        part.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < FL; i++) begin
            step(1'b1, vec[i].din, 1'b0);
        end
        for (int i = 0; i < FL; i++) begin
            check("post_rst_out_data", out_data, vec[i].dout);
            check("post_rst_out_idx", out_idx, vec[i].idx);
            step(1'b0, '0, 1'b1);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step(logic'($urandom_range(0, 1)), W'($urandom), logic'($urandom_range(0, 3) != 0));
        end
        flush();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bitrev_reorder_buf

// File: doc/bitrev_reorder_buf.md
BITREV_REORDER_BUF -- requirements
Module: bitrev_reorder_buf

Interface
REQ-001 SHALL have parameter N, default 3: log2 of FFT frame length; frame = 2^N samples.
REQ-002 SHALL have parameter W, default 16: sample width in bits.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1: an input sample is offered.
REQ-006 SHALL have port in_ready  output  1: the block can accept a sample this cycle.
REQ-007 SHALL have port in_data  input  W: input sample, presented in bit-reversed frame order.
REQ-008 SHALL have port out_valid  output  1: an output sample is presented.
REQ-009 SHALL have port out_ready  input  1: downstream accepts the sample this cycle.
REQ-010 SHALL have port out_data  output  W: output sample, in natural frame order.
REQ-011 SHALL have port out_idx  output  N: natural index of out_data within its frame.
REQ-012 SHALL have port out_last  output  1: high with the sample at out_idx = 2^N-1.

Function
REQ-013 SHALL transfer an input sample only on a rising edge where in_valid=1 and in_ready=1, and an output sample only where out_valid=1 and out_ready=1.
REQ-014 SHALL hold two banks of 2^N x W storage, used as a ping-pong pair, with per-bank full flags, a write-bank pointer, and a read-bank pointer.
REQ-015 SHALL write input sample k (0..2^N-1, counted per frame by wr_cnt) at address rev(k) of the write bank; rev mirrors bit i to bit N-1-i.
REQ-016 SHALL set the write bank's full flag, toggle the write-bank pointer and wrap wr_cnt to 0 on the edge that accepts sample 2^N-1.
REQ-017 SHALL drive in_ready = NOT full[write bank].
REQ-018 SHALL drive out_valid = full[read bank], with out_data = read bank[rd_cnt] and out_idx = rd_cnt.
REQ-019 SHALL advance rd_cnt on each output transfer; on the transfer with rd_cnt = 2^N-1 it SHALL clear full[read bank], toggle the read-bank pointer and wrap rd_cnt to 0.
REQ-020 SHALL raise out_valid in the cycle immediately after the edge that fills a bank; the latency from the last input to the first output is 1 cycle.
REQ-021 SHALL hold out_data, out_idx, out_last and out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL sustain 1 sample/cycle on both sides when out_ready is held at 1: no in_ready bubbles after the first frame.
REQ-023 SHALL apply both updates when a bank is filled and the other bank drains its last sample on the same edge; neither update is lost.
REQ-024 SHALL ignore in_data when in_ready=0, and SHALL leave storage and counters unchanged in that case.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously clear wr_cnt, rd_cnt, both bank pointers and both full flags.
REQ-026 SHALL output in_ready=1, out_valid=0, out_idx=0 and out_last=0 during reset.
REQ-027 SHALL leave storage contents unreset; out_data is don't-care while out_valid=0.
REQ-028 SHALL discard any partial frame when reset is asserted mid-frame; the first frame after reset starts at wr_cnt=0.

Structure
REQ-029 SHALL place the default values of N and W and the rev_bits function in a shared package, fft_pkg, for reuse by the shuffle-index generator.
REQ-030 SHALL implement each bank as one sub-module, reorder_bank_ram (2^N x W, one write port, one asynchronous read port), instantiated twice.

Verification
REQ-031 SHALL verify, with N=3: feed one frame in_data=0..7 with out_ready=1 -> out_data 0,4,2,6,1,5,3,7; out_idx 0..7; out_last on the 8th output; first out_valid 1 cycle after the 8th input.
REQ-032 SHALL verify: feed 4 back-to-back frames with out_ready=1 -> in_ready stays 1 throughout; 32 outputs with no gaps after the first frame.
REQ-033 SHALL verify: hold out_ready=0 and offer 20 samples -> in_ready falls after the 16th is accepted; samples 17-20 are held and are accepted only after the drain starts.
REQ-034 SHALL verify: toggle out_ready every cycle -> out_data and out_idx are unchanged across stalled cycles; the sequence matches REQ-031.
REQ-035 SHALL verify: align the 8th write of frame 2 with the 8th read of frame 1 on one edge -> both full flags are correct and frame 2 output follows with no gap.
REQ-036 SHALL verify: assert rst_n=0 after 5 inputs of a frame -> out_valid=0 and in_ready=1 immediately; a fresh frame 0..7 then yields the REQ-031 sequence.
